// File: rtl/ulpi_seq_pkg.sv
// Shared types, ULPI register addresses and the power-up register table for ulpi_reg_sequencer.
// Optional macro ULPI_SEQ_VERIFY_EN adds the write-readback state encoding.
package ulpi_seq_pkg;

    localparam logic [7:0] ULPI_REG_VID_LOW   = 8'h00;
    localparam logic [7:0] ULPI_REG_FUNC_CTRL = 8'h04;
    localparam logic [7:0] ULPI_REG_IF_CTRL   = 8'h07;
    localparam logic [7:0] ULPI_REG_OTG_CTRL  = 8'h0A;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } seq_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEQ_ISSUE = 3'd1,
        ST_SEQ_WAIT  = 3'd2,
        ST_SEQ_NEXT  = 3'd3,
        ST_EXT_ISSUE = 3'd4,
        ST_EXT_WAIT  = 3'd5,
`ifdef ULPI_SEQ_VERIFY_EN
        ST_END       = 3'd6,
        ST_SEQ_VERIFY = 3'd7
`else
        ST_END       = 3'd6
`endif
    } seq_state_e;

    // Read entries carry the expected value in the data field.
    function automatic seq_entry_t table_entry(input logic [1:0] idx);
        seq_entry_t e;
        case (idx)
            2'd0:    e = '{we: 1'b1, addr: ULPI_REG_FUNC_CTRL, data: 8'h45};
            2'd1:    e = '{we: 1'b1, addr: ULPI_REG_OTG_CTRL,  data: 8'h00};
            2'd2:    e = '{we: 1'b1, addr: ULPI_REG_IF_CTRL,   data: 8'h00};
            default: e = '{we: 1'b0, addr: ULPI_REG_VID_LOW,   data: 8'h24};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ulpi_reg_sequencer_timer.sv
// Loadable down-counter used as the register-port ack timeout.
// expired_o flags the enabled cycle in which the count reaches zero.
module ulpi_seq_timer #(
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned W = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    logic [W-1:0] cnt_q;

    // Countdown register: load takes priority over decrement, saturates at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= W'(TIMEOUT_CYC);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = en_i && (cnt_q <= W'(1));

endmodule

// File: rtl/ulpi_reg_sequencer.sv
// ULPI register-port sequencer: runs the PHY init table after start_i and arbitrates one
// external requester. Define ULPI_SEQ_VERIFY_EN to read back every table write.
module ulpi_reg_sequencer
    import ulpi_seq_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_idx_o,
    input  logic       ext_req_i,
    input  logic       ext_we_i,
    input  logic [7:0] ext_addr_i,
    input  logic [7:0] ext_data_i,
    output logic [7:0] ext_data_o,
    output logic       ext_ack_o,
    output logic       ext_err_o,
    output logic [7:0] reg_addr_o,
    output logic       reg_stb_o,
    output logic       reg_we_o,
    output logic [7:0] reg_data_o,
    input  logic [7:0] reg_data_i,
    input  logic       reg_ack_i
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    seq_state_e    state_q, state_d;
    logic [1:0]    idx_q, idx_d, err_idx_q, err_idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          pending_q, pending_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          ext_ack_q, ext_ack_d, ext_err_q, ext_err_d;
    logic [7:0]    ext_data_q, ext_data_d;
    logic          reg_stb_q, reg_stb_d, reg_we_q, reg_we_d;
    logic [7:0]    reg_addr_q, reg_addr_d, reg_data_q, reg_data_d;
    logic          timer_load_s, timer_en_s, timer_expired_s, seq_fail_s;
    seq_entry_t    cur_entry_s, issue_entry_s;
`ifdef ULPI_SEQ_VERIFY_EN
    logic          vphase_q, vphase_d;
`endif

    assign cur_entry_s   = table_entry(idx_q);
    assign issue_entry_s = table_entry(idx_d);

    ulpi_seq_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (timer_load_s),
        .en_i      (timer_en_s),
        .expired_o (timer_expired_s)
    );

    // Next-state and status logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        pending_d    = pending_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        err_idx_d    = err_idx_q;
        ext_ack_d    = 1'b0;
        ext_err_d    = 1'b0;
        ext_data_d   = ext_data_q;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;
        seq_fail_s   = 1'b0;
`ifdef ULPI_SEQ_VERIFY_EN
        vphase_d     = vphase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i || pending_q) begin
                    state_d   = ST_SEQ_ISSUE;
                    idx_d     = 2'd0;
                    retry_d   = '0;
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    err_idx_d = 2'd0;
                end else if (ext_req_i && !ext_ack_q) begin
                    // The requester still holds ext_req_i during its ack cycle.
                    state_d = ST_EXT_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEQ_ISSUE: begin
                timer_load_s = 1'b1;
`ifdef ULPI_SEQ_VERIFY_EN
                vphase_d     = 1'b0;
`endif
                state_d      = ST_SEQ_WAIT;
            end
`ifdef ULPI_SEQ_VERIFY_EN
            ST_SEQ_VERIFY: begin
                timer_load_s = 1'b1;
                vphase_d     = 1'b1;
                state_d      = ST_SEQ_WAIT;
            end
`endif
            ST_SEQ_WAIT: begin
                timer_en_s = 1'b1;
                if (reg_ack_i) begin
`ifdef ULPI_SEQ_VERIFY_EN
                    if (cur_entry_s.we && !vphase_q) begin
                        retry_d = '0;
                        state_d = ST_SEQ_VERIFY;
                    end else if (reg_data_i == cur_entry_s.data) begin
                        state_d = ST_SEQ_NEXT;
                    end else begin
                        seq_fail_s = 1'b1;
                    end
`else
                    if (cur_entry_s.we || (reg_data_i == cur_entry_s.data)) begin
                        state_d = ST_SEQ_NEXT;
                    end else begin
                        seq_fail_s = 1'b1;
                    end
`endif
                end else if (timer_expired_s) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
`ifdef ULPI_SEQ_VERIFY_EN
                        state_d = vphase_q ? ST_SEQ_VERIFY : ST_SEQ_ISSUE;
`else
                        state_d = ST_SEQ_ISSUE;
`endif
                    end else begin
                        seq_fail_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SEQ_WAIT;
                end
            end
            ST_SEQ_NEXT: begin
                retry_d = '0;
                if (idx_q == 2'(NUM_ENTRIES - 1)) begin
                    state_d = ST_END;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_SEQ_ISSUE;
                end
            end
            ST_END: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_EXT_ISSUE: begin
                timer_load_s = 1'b1;
                pending_d    = pending_q | start_i;
                busy_d       = busy_q | start_i;
                state_d      = ST_EXT_WAIT;
            end
            ST_EXT_WAIT: begin
                timer_en_s = 1'b1;
                pending_d  = pending_q | start_i;
                busy_d     = busy_q | start_i;
                if (reg_ack_i) begin
                    ext_ack_d  = 1'b1;
                    ext_data_d = reg_we_q ? ext_data_q : reg_data_i;
                    state_d    = ST_IDLE;
                end else if (timer_expired_s) begin
                    ext_ack_d = 1'b1;
                    ext_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_EXT_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        state_d   = seq_fail_s ? ST_IDLE : state_d;
        err_d     = seq_fail_s ? 1'b1    : err_d;
        err_idx_d = seq_fail_s ? idx_q   : err_idx_d;
        busy_d    = seq_fail_s ? 1'b0    : busy_d;
        retry_d   = seq_fail_s ? '0      : retry_d;
    end

    // Bus request fields, registered together with the one-cycle strobe.
    always_comb begin
        reg_stb_d  = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_we_d   = reg_we_q;
        reg_data_d = reg_data_q;
        case (state_d)
            ST_SEQ_ISSUE: begin
                reg_stb_d  = 1'b1;
                reg_addr_d = issue_entry_s.addr;
                reg_we_d   = issue_entry_s.we;
                reg_data_d = issue_entry_s.data;
            end
`ifdef ULPI_SEQ_VERIFY_EN
            ST_SEQ_VERIFY: begin
                reg_stb_d  = 1'b1;
                reg_addr_d = issue_entry_s.addr;
                reg_we_d   = 1'b0;
            end
`endif
            ST_EXT_ISSUE: begin
                reg_stb_d  = 1'b1;
                reg_addr_d = ext_addr_i;
                reg_we_d   = ext_we_i;
                reg_data_d = ext_data_i;
            end
            default: begin
                reg_stb_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            retry_q    <= '0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= 2'd0;
            ext_ack_q  <= 1'b0;
            ext_err_q  <= 1'b0;
            ext_data_q <= 8'h00;
            reg_stb_q  <= 1'b0;
            reg_addr_q <= 8'h00;
            reg_we_q   <= 1'b0;
            reg_data_q <= 8'h00;
`ifdef ULPI_SEQ_VERIFY_EN
            vphase_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
            ext_ack_q  <= ext_ack_d;
            ext_err_q  <= ext_err_d;
            ext_data_q <= ext_data_d;
            reg_stb_q  <= reg_stb_d;
            reg_addr_q <= reg_addr_d;
            reg_we_q   <= reg_we_d;
            reg_data_q <= reg_data_d;
`ifdef ULPI_SEQ_VERIFY_EN
            vphase_q   <= vphase_d;
`endif
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_idx_o  = err_idx_q;
    assign ext_ack_o  = ext_ack_q;
    assign ext_err_o  = ext_err_q;
    assign ext_data_o = ext_data_q;
    assign reg_stb_o  = reg_stb_q;
    assign reg_addr_o = reg_addr_q;
    assign reg_we_o   = reg_we_q;
    assign reg_data_o = reg_data_q;

endmodule

// File: tb/tb_ulpi_reg_sequencer.sv
// Directed bench for ulpi_reg_sequencer with a small PHY register model that acks two
// cycles after each strobe and can withhold acks or corrupt readback.
module tb_ulpi_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, ext_req, ext_we;
    logic [7:0] ext_addr, ext_wdata;
    logic       busy_o, done_o, err_o, ext_ack_o, ext_err_o, reg_stb_o, reg_we_o;
    logic [1:0] err_idx_o;
    logic [7:0] ext_data_o, reg_addr_o, reg_data_o;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem [256];
    logic       withhold_en = 1'b0;
    logic [7:0] withhold_addr = 8'h00;
    logic       corrupt_en = 1'b0;
    int         ack_cnt = 0;
    logic [7:0] pend_addr, pend_data;
    logic       pend_we;
    int         stb_n = 0;
    logic [7:0] log_addr [64];
    logic [7:0] log_data [64];
    logic       log_we   [64];
    int         log_cyc  [64];

    ulpi_reg_sequencer dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_idx_o  (err_idx_o),
        .ext_req_i  (ext_req),
        .ext_we_i   (ext_we),
        .ext_addr_i (ext_addr),
        .ext_data_i (ext_wdata),
        .ext_data_o (ext_data_o),
        .ext_ack_o  (ext_ack_o),
        .ext_err_o  (ext_err_o),
        .reg_addr_o (reg_addr_o),
        .reg_stb_o  (reg_stb_o),
        .reg_we_o   (reg_we_o),
        .reg_data_o (reg_data_o),
        .reg_data_i (reg_rdata),
        .reg_ack_i  (reg_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PHY model: log every strobe, ack it two cycles later unless withheld.
    always @(negedge clk) begin
        reg_ack = 1'b0;
        if (ack_cnt > 0) begin
            ack_cnt = ack_cnt - 1;
            if (ack_cnt == 0) begin
                reg_ack = 1'b1;
                if (pend_we) mem[pend_addr] = pend_data;
                else reg_rdata = (corrupt_en && pend_addr == 8'h0A) ? 8'h01 : mem[pend_addr];
            end
        end
        if (reg_stb_o) begin
            if (stb_n < 64) begin
                log_addr[stb_n] = reg_addr_o;
                log_data[stb_n] = reg_data_o;
                log_we[stb_n]   = reg_we_o;
                log_cyc[stb_n]  = cyc;
            end
            stb_n = stb_n + 1;
            if (!(withhold_en && reg_addr_o == withhold_addr)) begin
                ack_cnt   = 2;
                pend_addr = reg_addr_o;
                pend_data = reg_data_o;
                pend_we   = reg_we_o;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!busy_o && (done_o || err_o)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_ext(input int bound, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ext_ack_o) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, err_o, err_idx_o, ext_ack_o, ext_err_o, ext_data_o, reg_stb_o,
             reg_addr_o, reg_we_o, reg_data_o} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b stb=%b addr=%h, required all 0",
                     busy_o, done_o, err_o, reg_stb_o, reg_addr_o);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (stb_n !== 0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d strobes, required 0", stb_n);
        end
    endtask

    task automatic test_table_ok();
        logic [7:0] ea [4] = '{8'h04, 8'h0A, 8'h07, 8'h00};
        logic [7:0] ed [4] = '{8'h45, 8'h00, 8'h00, 8'h00};
        logic       ew [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int base = stb_n;
        bit ok;
        pulse_start();
        wait_run(100, ok);
        checks++;
        if (!ok || stb_n - base !== 4) begin
            errors++;
            $display("FAIL table_count: got ok=%b strobes=%0d, required ok=1 strobes=4", ok, stb_n - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[base+i] !== ea[i] || log_we[base+i] !== ew[i] ||
                (ew[i] && log_data[base+i] !== ed[i])) begin
                errors++;
                $display("FAIL table_entry%0d: got addr=%h we=%b data=%h, required addr=%h we=%b data=%h",
                         i, log_addr[base+i], log_we[base+i], log_data[base+i], ea[i], ew[i], ed[i]);
            end
        end
        checks++;
        if (log_cyc[base+1] - log_cyc[base] !== 4) begin
            errors++;
            $display("FAIL table_spacing: got %0d cycles, required 4", log_cyc[base+1] - log_cyc[base]);
        end
        checks++;
        if ({done_o, err_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL table_status: got done/err/busy=%b, required 100", {done_o, err_o, busy_o});
        end
    endtask

    task automatic test_vid_mismatch();
        bit ok;
        mem[0] = 8'h25;
        pulse_start();
        wait_run(100, ok);
        checks++;
        if (!ok || {done_o, err_o, err_idx_o, busy_o} !== 5'b01110) begin
            errors++;
            $display("FAIL vid_mismatch: got done=%b err=%b idx=%0d busy=%b, required 0 1 3 0",
                     done_o, err_o, err_idx_o, busy_o);
        end
        mem[0] = 8'h24;
    endtask

    task automatic test_timeout();
        int base = stb_n;
        bit ok;
        withhold_addr = 8'h0A;
        withhold_en   = 1'b1;
        pulse_start();
        wait_run(1500, ok);
        checks++;
        if (!ok || stb_n - base !== 4) begin
            errors++;
            $display("FAIL timeout_count: got ok=%b strobes=%0d, required ok=1 strobes=4", ok, stb_n - base);
        end
        for (int i = 2; i < 4; i++) begin
            checks++;
            if (log_addr[base+i] !== 8'h0A || log_cyc[base+i] - log_cyc[base+i-1] !== 256) begin
                errors++;
                $display("FAIL timeout_retry%0d: got addr=%h spacing=%0d, required addr=0a spacing=256",
                         i - 1, log_addr[base+i], log_cyc[base+i] - log_cyc[base+i-1]);
            end
        end
        checks++;
        if ({done_o, err_o, err_idx_o} !== 4'b0101) begin
            errors++;
            $display("FAIL timeout_status: got done=%b err=%b idx=%0d, required 0 1 1", done_o, err_o, err_idx_o);
        end
        withhold_en = 1'b0;
    endtask

    task automatic test_ext_read();
        int base = stb_n;
        int at;
        bit ok;
        @(negedge clk);
        ext_addr = 8'h16;
        ext_we   = 1'b0;
        ext_req  = 1'b1;
        wait_ext(20, ok, at);
        ext_req = 1'b0;
        checks++;
        if (!ok || ext_data_o !== 8'hA5 || ext_err_o !== 1'b0) begin
            errors++;
            $display("FAIL ext_read_data: got ok=%b data=%h err=%b, required ok=1 data=a5 err=0", ok, ext_data_o, ext_err_o);
        end
        checks++;
        if (stb_n - base !== 1 || log_addr[base] !== 8'h16 || log_we[base] !== 1'b0 || at - log_cyc[base] !== 3) begin
            errors++;
            $display("FAIL ext_read_bus: got strobes=%0d addr=%h we=%b latency=%0d, required 1 16 0 3",
                     stb_n - base, log_addr[base], log_we[base], at - log_cyc[base]);
        end
        @(negedge clk);
        checks++;
        if (ext_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL ext_ack_pulse: got ext_ack_o=%b one cycle later, required 0", ext_ack_o);
        end
    endtask

    task automatic test_ext_with_start();
        int base = stb_n;
        int at;
        bit ok;
        @(negedge clk);
        ext_addr = 8'h16;
        ext_we   = 1'b0;
        ext_req  = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL pending_busy: got busy_o=%b, required 1", busy_o);
        end
        wait_ext(20, ok, at);
        ext_req = 1'b0;
        wait_run(100, ok);
        checks++;
        if (stb_n - base !== 5 || log_addr[base+1] !== 8'h04 || log_cyc[base+1] !== at + 1) begin
            errors++;
            $display("FAIL pending_start: got strobes=%0d addr=%h stb_cyc=%0d, required 5 04 %0d",
                     stb_n - base, log_addr[base+1], log_cyc[base+1], at + 1);
        end
        checks++;
        if (!ok || done_o !== 1'b1) begin
            errors++;
            $display("FAIL pending_done: got ok=%b done=%b, required 1 1", ok, done_o);
        end
    endtask

    task automatic test_start_and_ext();
        int base = stb_n;
        int at;
        bit ok;
        @(negedge clk);
        start    = 1'b1;
        ext_addr = 8'h16;
        ext_we   = 1'b0;
        ext_req  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ext(200, ok, at);
        ext_req = 1'b0;
        checks++;
        if (!ok || stb_n - base !== 5 || log_addr[base] !== 8'h04 || log_addr[base+4] !== 8'h16 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL seq_priority: got ok=%b strobes=%0d first=%h last=%h done=%b, required 1 5 04 16 1",
                     ok, stb_n - base, log_addr[base], log_addr[base+4], done_o);
        end
    endtask

    task automatic test_reset_mid();
        int base = stb_n;
        pulse_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy_o, done_o, err_o, err_idx_o, ext_ack_o, ext_err_o, ext_data_o, reg_stb_o,
             reg_addr_o, reg_we_o, reg_data_o} !== 33'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b stb=%b addr=%h, required all 0",
                     busy_o, done_o, reg_stb_o, reg_addr_o);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (stb_n - base !== 1 || {busy_o, done_o, err_o} !== 3'b000) begin
            errors++;
            $display("FAIL late_ack: got strobes=%0d busy/done/err=%b, required 1 000",
                     stb_n - base, {busy_o, done_o, err_o});
        end
    endtask

    task automatic test_ext_timeout();
        int base = stb_n;
        int at;
        bit ok;
        withhold_addr = 8'h33;
        withhold_en   = 1'b1;
        @(negedge clk);
        ext_addr = 8'h33;
        ext_we   = 1'b0;
        ext_req  = 1'b1;
        wait_ext(400, ok, at);
        ext_req = 1'b0;
        checks++;
        if (!ok || ext_err_o !== 1'b1 || ext_data_o !== 8'h00 || stb_n - base !== 1 || at - log_cyc[base] !== 256) begin
            errors++;
            $display("FAIL ext_timeout: got ok=%b err=%b data=%h strobes=%0d latency=%0d, required 1 1 00 1 256",
                     ok, ext_err_o, ext_data_o, stb_n - base, at - log_cyc[base]);
        end
        withhold_en = 1'b0;
    endtask

    task automatic test_verify();
        bit ok;
        corrupt_en = 1'b1;
        pulse_start();
        wait_run(200, ok);
        checks++;
`ifdef ULPI_SEQ_VERIFY_EN
        if (!ok || {done_o, err_o, err_idx_o} !== 4'b0101) begin
            errors++;
            $display("FAIL verify_corrupt: got done=%b err=%b idx=%0d, required 0 1 1", done_o, err_o, err_idx_o);
        end
`else
        if (!ok || {done_o, err_o} !== 2'b10) begin
            errors++;
            $display("FAIL verify_absent: got done=%b err=%b, required 1 0", done_o, err_o);
        end
`endif
        corrupt_en = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ext_req   = 1'b0;
        ext_we    = 1'b0;
        ext_addr  = 8'h00;
        ext_wdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h24;
        mem[8'h16] = 8'hA5;
        test_reset();
        test_table_ok();
        test_vid_mismatch();
        test_timeout();
        test_ext_read();
        test_ext_with_start();
        test_start_and_ext();
        test_reset_mid();
        test_ext_timeout();
        test_verify();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
